// File: rtl/coarse_peak_finder_if.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | coarse_peak_finder_if : TDC hit input and peak-result output bundle       |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface coarse_peak_finder_if #(
  parameter int NB = 4,
  parameter int NP = 8,
  parameter int NC = 8
);
  logic          tdcValid;
  logic [NP-1:0] tdcData;
  logic          frameEnd;
  logic          accumReady;
  logic [NB-1:0] peakCH;
  logic [NC-1:0] peakCount;
  logic          peakEmpty;
  logic          peakDone;

  // master: hit source / consumer of the peak result
  modport master (
    output tdcValid, tdcData, frameEnd,
    input  accumReady, peakCH, peakCount, peakEmpty, peakDone
  );

  // slave: the peak finder itself
  modport slave (
    input  tdcValid, tdcData, frameEnd,
    output accumReady, peakCH, peakCount, peakEmpty, peakDone
  );
endinterface
`default_nettype wire

// File: rtl/coarse_peak_finder.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | coarse_peak_finder : per-frame coarse histogram of TDC hits + peak search |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module coarse_peak_finder #(
  parameter int NB = 4,
  parameter int NP = 8,
  parameter int NC = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  coarse_peak_finder_if.slave  pf
);

  localparam int            NBINS    = 1 << NB;
  localparam logic [NB-1:0] LAST_IDX = {NB{1'b1}};
  localparam logic [NC-1:0] CNT_MAX  = {NC{1'b1}};

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_SEARCH = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t        state_q,      state_d;
  logic [NB-1:0] idx_q,        idx_d;
  logic [NC-1:0] max_val_q,    max_val_d;
  logic [NB-1:0] max_idx_q,    max_idx_d;
  logic [NB-1:0] peak_ch_q,    peak_ch_d;
  logic [NC-1:0] peak_count_q, peak_count_d;
  logic          peak_empty_q, peak_empty_d;

  logic [NC-1:0] bin_q [NBINS];
  logic          bin_we;
  logic [NB-1:0] bin_waddr;
  logic [NC-1:0] bin_wdata;

  logic [NB-1:0] hit_bin;
  logic [NC-1:0] hit_cnt;
  logic [NC-1:0] scan_cnt;
  logic          unused_tdc_bits;

  // Only the top NB timestamp bits select the coarse bin.
  assign hit_bin         = pf.tdcData[NP-1 -: NB];
  assign hit_cnt         = bin_q[hit_bin];
  assign scan_cnt        = bin_q[idx_q];
  assign unused_tdc_bits = ^pf.tdcData;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    max_val_d    = max_val_q;
    max_idx_d    = max_idx_q;
    peak_ch_d    = peak_ch_q;
    peak_count_d = peak_count_q;
    peak_empty_d = peak_empty_q;
    bin_we       = 1'b0;
    bin_waddr    = idx_q;
    bin_wdata    = '0;

    case (state_q)
      ST_CLEAR: begin
        bin_we    = 1'b1;
        bin_waddr = idx_q;
        bin_wdata = '0;
        idx_d     = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = ST_ACCUM;
        end
      end

      ST_ACCUM: begin
        // Saturated bins simply skip the write.
        if (pf.tdcValid && (hit_cnt != CNT_MAX)) begin
          bin_we    = 1'b1;
          bin_waddr = hit_bin;
          bin_wdata = hit_cnt + 1'b1;
        end
        if (pf.frameEnd) begin
          state_d   = ST_SEARCH;
          idx_d     = '0;
          max_val_d = '0;
          max_idx_d = '0;
        end
      end

      ST_SEARCH: begin
        // Strictly-greater replacement keeps the lowest index on ties.
        if (scan_cnt > max_val_q) begin
          max_val_d = scan_cnt;
          max_idx_d = idx_q;
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d      = ST_DONE;
          peak_empty_d = (max_val_d == '0);
          peak_ch_d    = (max_val_d == '0) ? '0 : max_idx_d;
          peak_count_d = max_val_d;
        end
      end

      ST_DONE: begin
        state_d = ST_CLEAR;
        idx_d   = '0;
      end

      default: begin
        state_d = ST_CLEAR;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_CLEAR;
      idx_q        <= '0;
      max_val_q    <= '0;
      max_idx_q    <= '0;
      peak_ch_q    <= '0;
      peak_count_q <= '0;
      peak_empty_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      max_val_q    <= max_val_d;
      max_idx_q    <= max_idx_d;
      peak_ch_q    <= peak_ch_d;
      peak_count_q <= peak_count_d;
      peak_empty_q <= peak_empty_d;
    end
  end

  // Bin storage is not reset; the CLEAR sweep initialises it every frame.
  always_ff @(posedge clk) begin
    if (bin_we) begin
      bin_q[bin_waddr] <= bin_wdata;
    end
  end

  assign pf.accumReady = (state_q == ST_ACCUM);
  assign pf.peakDone   = (state_q == ST_DONE);
  assign pf.peakCH     = peak_ch_q;
  assign pf.peakCount  = peak_count_q;
  assign pf.peakEmpty  = peak_empty_q;

endmodule
`default_nettype wire
